// File: rtl/sc_mac_accum_if.sv
// Handshake/data bundle between the stochastic MAC accumulator and its
// multiplier/downstream consumer.
interface sc_mac_accum_if #(
  parameter int unsigned DATAWD = 8,
  parameter int unsigned NTERM  = 16
) ();
  localparam int unsigned TermWd = $clog2(NTERM);
  localparam int unsigned ACCWD  = DATAWD + TermWd;

  logic              iStart;
  logic              iAbort;
  logic              iBit;
  logic              iReady;
  logic              oLoad;
  logic [TermWd-1:0] oTermIdx;
  logic              oBusy;
  logic              oValid;
  logic [ACCWD-1:0]  oAcc;
  logic [DATAWD-1:0] oC;

  // Accumulator side.
  modport slave (
    input  iStart,
    input  iAbort,
    input  iBit,
    input  iReady,
    output oLoad,
    output oTermIdx,
    output oBusy,
    output oValid,
    output oAcc,
    output oC
  );

  // Controller / consumer side.
  modport master (
    output iStart,
    output iAbort,
    output iBit,
    output iReady,
    input  oLoad,
    input  oTermIdx,
    input  oBusy,
    input  oValid,
    input  oAcc,
    input  oC
  );
endinterface

// File: rtl/sc_mac_accum.sv
// Stochastic MAC accumulator: counts ones of a product bitstream over NTERM
// windows of 2^DATAWD-1 cycles each, then presents raw and scaled sums.
module sc_mac_accum #(
  parameter int unsigned DATAWD = 8,
  parameter int unsigned NTERM  = 16,
  parameter int unsigned SHIFT  = $clog2(NTERM)
) (
  input logic          clk,
  input logic          rst_n,
  sc_mac_accum_if.slave bus
);
  localparam int unsigned TermWd = $clog2(NTERM);
  localparam int unsigned ACCWD  = DATAWD + TermWd;
  localparam int unsigned Win    = (1 << DATAWD) - 1;

  localparam logic [DATAWD-1:0] WinLast  = DATAWD'(Win - 1);
  localparam logic [TermWd-1:0] TermLast = TermWd'(NTERM - 1);
  localparam logic [ACCWD-1:0]  AccMax   = ACCWD'(NTERM * Win);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e            state_q;
  logic [ACCWD-1:0]  acc_q;
  logic [TermWd-1:0] term_q;
  logic [DATAWD-1:0] win_q;

  // Abort outranks start and handshake; it also wipes the partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      term_q  <= '0;
      win_q   <= '0;
    end else if (bus.iAbort) begin
      state_q <= StIdle;
      acc_q   <= '0;
      term_q  <= '0;
      win_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.iStart) begin
            state_q <= StLoad;
            acc_q   <= '0;
            term_q  <= '0;
            win_q   <= '0;
          end
        end
        StLoad: begin
          state_q <= StRun;
        end
        StRun: begin
          acc_q <= acc_q + ACCWD'(bus.iBit);
          if (win_q == WinLast) begin
            win_q   <= '0;
            term_q  <= term_q + 1'b1;
            state_q <= (term_q == TermLast) ? StDone : StLoad;
          end else begin
            win_q <= win_q + 1'b1;
          end
        end
        StDone: begin
          if (bus.iReady) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.oLoad    = (state_q == StLoad);
  assign bus.oBusy    = (state_q == StLoad) || (state_q == StRun);
  assign bus.oValid   = (state_q == StDone);
  assign bus.oTermIdx = term_q;
  assign bus.oAcc     = acc_q;
  assign bus.oC       = DATAWD'(acc_q >> SHIFT);

  // One bit per RUN cycle can never push the count past NTERM full windows.
  assert property (@(posedge clk) disable iff (!rst_n) win_q <= WinLast);
  assert property (@(posedge clk) disable iff (!rst_n) acc_q <= AccMax);

endmodule

// File: tb/tb_sc_mac_accum.sv
// Randomised scoreboard bench for sc_mac_accum: stimulus pushes expected load
// events and results, a negedge monitor pops and compares them.
module tb_sc_mac_accum;
  localparam int DW  = 8;
  localparam int NT  = 16;
  localparam int SH  = 4;
  localparam int WIN = (1 << DW) - 1;
  localparam int PER = WIN + 1;
  localparam int LAT = NT * PER;

  typedef struct {
    int cyc;
    int idx;
  } load_t;

  typedef struct {
    int acc;
    int c;
    int cyc;
  } res_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  load_t load_q[$];
  res_t  res_q[$];

  sc_mac_accum_if #(.DATAWD(DW), .NTERM(NT)) bus ();

  sc_mac_accum #(
    .DATAWD(DW),
    .NTERM (NT),
    .SHIFT (SH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen with nothing expected (t=%0t)", name, $time);
  endtask

  // Monitor: compares DUT events against what the stimulus predicted.
  bit prev_valid;
  int first_cyc;
  int hold_acc;
  int hold_c;
  int hold_idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.oLoad) begin
        if (load_q.size() == 0) begin
          flag("unexpected oLoad");
        end else begin
          load_t l;
          l = load_q.pop_front();
          chk("oLoad cycle", cyc, l.cyc);
          chk("oTermIdx at load", int'(bus.oTermIdx), l.idx);
        end
      end
      if (bus.oValid) begin
        if (!prev_valid) begin
          first_cyc = cyc;
          hold_acc  = int'(bus.oAcc);
          hold_c    = int'(bus.oC);
          hold_idx  = int'(bus.oTermIdx);
        end else begin
          chk("oAcc stable in done", int'(bus.oAcc), hold_acc);
          chk("oC stable in done", int'(bus.oC), hold_c);
          chk("oTermIdx stable in done", int'(bus.oTermIdx), hold_idx);
        end
        if (bus.iReady) begin
          if (res_q.size() == 0) begin
            flag("unexpected result");
          end else begin
            res_t r;
            r = res_q.pop_front();
            chk("oAcc result", int'(bus.oAcc), r.acc);
            chk("oC result", int'(bus.oC), r.c);
            chk("first oValid cycle", first_cyc, r.cyc);
          end
        end
      end
      prev_valid = bus.oValid;
    end
  end

  // mode 0: all ones, 1: all zeros, 2: ones in term 0 and every LOAD, else random
  function automatic bit pick(input int mode, input int n, input int thr);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (n <= PER) || (((n - 1) % PER) == 0);
      default: return $urandom_range(0, 255) < thr;
    endcase
  endfunction

  task automatic check_cleared(input string tag);
    chk({tag, " oBusy"}, int'(bus.oBusy), 0);
    chk({tag, " oValid"}, int'(bus.oValid), 0);
    chk({tag, " oLoad"}, int'(bus.oLoad), 0);
    chk({tag, " oAcc"}, int'(bus.oAcc), 0);
    chk({tag, " oC"}, int'(bus.oC), 0);
    chk({tag, " oTermIdx"}, int'(bus.oTermIdx), 0);
  endtask

  // One MAC. Cycle n (1-based after the iStart edge) is a LOAD cycle when
  // (n-1) is a multiple of WIN+1, otherwise a RUN cycle whose bit counts.
  task automatic run_mac(input int mode, input int rdy_dly, input bit poke,
                         input int cut_at, input bit cut_rst);
    int sum;
    int c0;
    int thr;
    bit b;
    bit is_load;
    sum = 0;
    thr = $urandom_range(0, 256);
    bus.iStart = 1'b1;
    @(posedge clk);
    #1;
    bus.iStart = 1'b0;
    c0 = cyc;
    for (int n = 1; n <= LAT; n++) begin
      is_load = ((n - 1) % PER) == 0;
      if (is_load) load_q.push_back('{cyc: c0 + n - 1, idx: (n - 1) / PER});
      b = pick(mode, n, thr);
      bus.iBit = b;
      if (!is_load) sum += int'(b);
      if (cut_at != 0 && n == cut_at) begin
        if (cut_rst) begin
          #2;
          rst_n = 1'b0;
          #1;
          check_cleared("async reset mid-run");
          @(posedge clk);
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          bus.iBit = 1'b0;
          @(posedge clk);
          #1;
          chk("idle after reset release oBusy", int'(bus.oBusy), 0);
        end else begin
          bus.iAbort = 1'b1;
          @(posedge clk);
          #1;
          bus.iAbort = 1'b0;
          bus.iBit = 1'b0;
          check_cleared("abort mid-run");
        end
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.iBit = 1'b0;
    res_q.push_back('{acc: sum, c: sum >> SH, cyc: c0 + LAT});
    chk("oValid at latency", int'(bus.oValid), 1);
    chk("oBusy in done", int'(bus.oBusy), 0);
    for (int i = 0; i < rdy_dly; i++) begin
      if (poke && i == rdy_dly / 2) bus.iStart = 1'b1;
      @(posedge clk);
      #1;
      bus.iStart = 1'b0;
      chk("oValid held without iReady", int'(bus.oValid), 1);
    end
    bus.iReady = 1'b1;
    @(posedge clk);
    #1;
    bus.iReady = 1'b0;
    chk("oValid after handshake", int'(bus.oValid), 0);
    chk("oBusy after handshake", int'(bus.oBusy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("oAcc retained in idle", int'(bus.oAcc), sum);
    chk("oBusy stays low in idle", int'(bus.oBusy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    bus.iStart = 1'b0;
    bus.iAbort = 1'b0;
    bus.iBit   = 1'b0;
    bus.iReady = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle after reset oBusy", int'(bus.oBusy), 0);
    chk("idle after reset oLoad", int'(bus.oLoad), 0);

    run_mac(0, 0, 1'b0, 0, 1'b0);
    run_mac(1, 3, 1'b0, 0, 1'b0);
    run_mac(2, 0, 1'b0, 0, 1'b0);
    run_mac(3, 10, 1'b1, 0, 1'b0);
    run_mac(3, 0, 1'b0, 7 * PER + 100, 1'b0);
    run_mac(3, 2, 1'b0, 0, 1'b0);

    // Abort wins over a simultaneous start in IDLE.
    bus.iAbort = 1'b1;
    bus.iStart = 1'b1;
    @(posedge clk);
    #1;
    bus.iAbort = 1'b0;
    bus.iStart = 1'b0;
    chk("abort+start oBusy", int'(bus.oBusy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort+start still idle", int'(bus.oBusy), 0);

    run_mac(0, 0, 1'b0, 7 * PER + 37, 1'b1);
    run_mac(3, 1, 1'b0, 0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("pending load events", load_q.size(), 0);
    chk("pending results", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
